// File: rtl/coin_seq_pkg.sv
// Shared types for the coin sequencer: FSM state encoding, coin codes and
// the slot-to-coin mapping used when coins are written into the FIFO.
package coin_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_ONE  = 2'd1,
    COIN_TWO  = 2'd2,
    COIN_FIVE = 2'd3
  } coin_e;

  localparam int NUM_SLOTS = 3;

  // Slot 0 is the $1 sensor, slot 1 the $2, slot 2 the $5.
  function automatic coin_e slot_coin(input int unsigned slot);
    case (slot)
      0:       return COIN_ONE;
      1:       return COIN_TWO;
      2:       return COIN_FIVE;
      default: return COIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/coin_sequencer_if.sv
// Coin sensor / vending FSM signal bundle for the coin sequencer.
// The slave modport is the sequencer side; master is the environment side.
interface coin_sequencer_if #(
  parameter int DEPTH = 8
);
  logic                     coin_one_in;
  logic                     coin_two_in;
  logic                     coin_five_in;
  logic                     vm_d;
  logic                     one;
  logic                     two;
  logic                     five;
  logic [2:0]               coin_reject;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output coin_one_in, coin_two_in, coin_five_in, vm_d,
    input  one, two, five, coin_reject, busy, fifo_count
  );

  modport slave (
    input  coin_one_in, coin_two_in, coin_five_in, vm_d,
    output one, two, five, coin_reject, busy, fifo_count
  );

endinterface

// File: rtl/coin_fifo.sv
// Coin FIFO: up to three pushes (slot order one, two, five) and one pop per
// cycle. Free space is taken before the same-cycle pop; excess coins drop.
module coin_fifo
  import coin_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             push_req,
  input  logic                   pop,
  output coin_e                  head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic [2:0]             drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  coin_e          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  free;
  logic [CW-1:0]  n_acc;
  logic [2:0]     accept;
  logic [PW-1:0]  wr_idx [NUM_SLOTS];
  logic           pop_ok;

  // NOTE: blocking '=' is correct here: n_acc is a running sum that each
  // loop iteration must see updated, and every output gets a default first.
  always_comb begin
    free   = CW'(DEPTH) - count_q;
    n_acc  = '0;
    accept = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      wr_idx[i] = wr_ptr + n_acc[PW-1:0];
      if (push_req[i] && (n_acc < free)) begin
        accept[i] = 1'b1;
        n_acc     = n_acc + CW'(1);
      end
    end
  end

  assign drop   = push_req & ~accept;
  assign empty  = (count_q == '0);
  assign pop_ok = pop && !empty;
  assign head   = mem[rd_ptr];
  assign count  = count_q;

  // NOTE: storage is deliberately not reset; clearing the pointers and count
  // makes old contents unreachable, and a reset-free array maps to plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (accept[i]) mem[wr_idx[i]] <= slot_coin(i);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + n_acc[PW-1:0];
      rd_ptr  <= rd_ptr + PW'(pop_ok);
      count_q <= count_q + n_acc - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/coin_sequencer.sv
// Coin sequencer: queues slot pulses and issues one-hot coin strobes to the
// vending FSM, pausing GAP cycles after a dispense. Optional COIN_SEQ_STATS_EN.
module coin_sequencer
  import coin_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic               clk,
  input  logic               reset,
  coin_sequencer_if.slave    bus
`ifdef COIN_SEQ_STATS_EN
  ,
  output logic [7:0]         coin_total
`endif
);

  localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
  localparam int GW      = $clog2(GAP_EFF + 1);

  state_e                 state;
  logic [GW-1:0]          gap_cnt;
  coin_e                  head;
  logic                   fifo_empty;
  logic [2:0]             drop;
  logic [$clog2(DEPTH):0] count;
  logic                   issue_next;

  coin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_req ({bus.coin_five_in, bus.coin_two_in, bus.coin_one_in}),
    .pop      (state == ISSUE),
    .head     (head),
    .count    (count),
    .empty    (fifo_empty),
    .drop     (drop)
  );

  assign bus.fifo_count = count;
  assign bus.busy       = (state != IDLE) || !fifo_empty;

  // Strobes are registered, so the coin is chosen one cycle ahead from the head.
  assign issue_next = !fifo_empty &&
                      ((state == IDLE) || ((state == CHECK) && !bus.vm_d));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      bus.one         <= 1'b0;
      bus.two         <= 1'b0;
      bus.five        <= 1'b0;
      bus.coin_reject <= 3'b000;
    end else begin
      bus.one         <= issue_next && (head == COIN_ONE);
      bus.two         <= issue_next && (head == COIN_TWO);
      bus.five        <= issue_next && (head == COIN_FIVE);
      bus.coin_reject <= drop;
      unique case (state)
        IDLE: begin
          if (issue_next) state <= ISSUE;
        end
        ISSUE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (bus.vm_d) begin
            state   <= HOLD;
            gap_cnt <= GW'(GAP_EFF);
          end else if (issue_next) begin
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          gap_cnt <= (gap_cnt != '0) ? gap_cnt - GW'(1) : '0;
          if (gap_cnt <= GW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COIN_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      coin_total <= 8'd0;
    end else if ((state == ISSUE) && (coin_total != 8'hFF)) begin
      coin_total <= coin_total + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_sequencer.sv
// Self-checking bench for coin_sequencer: a directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_coin_sequencer;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int G_EFF = (GAP < 1) ? 1 : GAP;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coin_sequencer_if #(.DEPTH(DEPTH)) bus ();

`ifdef COIN_SEQ_STATS_EN
  logic [7:0] coin_total;
`endif

  coin_sequencer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef COIN_SEQ_STATS_EN
    ,
    .coin_total (coin_total)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of coin values plus a few cycle stamps.
  int         q[$];
  int         cyc         = 0;
  int         last_s      = -100;
  int         decide_from = 0;
  int         m_code      = 0;
  int         total       = 0;
  logic [2:0] m_rej       = 3'b000;

  typedef struct {
    logic          rst;
    logic [2:0]    coins;   // {five,two,one}
    logic          vm;
    bit            chk;
    logic [2:0]    strobe;  // {five,two,one}
    logic [2:0]    rej;
    logic          busy;
    logic [CW-1:0] count;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] code_to_strobe(input int code);
    case (code)
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] strobe_now();
    return {bus.five, bus.two, bus.one};
  endfunction

  function automatic logic [6+CW:0] dut_outputs();
    return {bus.five, bus.two, bus.one, bus.coin_reject, bus.busy, bus.fifo_count};
  endfunction

  function automatic logic [6+CW:0] model_expect();
    logic [2:0] s;
    logic       b;
    s = (cyc == last_s) ? code_to_strobe(m_code) : 3'b000;
    b = (q.size() > 0) || (cyc == last_s) || (cyc == last_s + 1) || (cyc < decide_from);
    return {s, m_rej, b, CW'(q.size())};
  endfunction

  task automatic model_step(input logic r, input logic [2:0] coins, input logic v);
    bit fire;
    int code;
    int free;
    if (r) begin
      q.delete();
      m_rej       = 3'b000;
      last_s      = -100;
      decide_from = cyc + 1;
      total       = 0;
    end else begin
      if ((cyc == last_s + 1) && v) decide_from = cyc + 1 + G_EFF;
      fire = (cyc >= decide_from) && (cyc != last_s) && (q.size() > 0);
      code = fire ? q[0] : 0;
      free = DEPTH - q.size();
      m_rej = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (coins[i]) begin
          if (free > 0) begin
            q.push_back(i + 1);
            free--;
          end else begin
            m_rej[i] = 1'b1;
          end
        end
      end
      if (cyc == last_s) void'(q.pop_front());
      if (fire) begin
        last_s = cyc + 1;
        m_code = code;
        if (total < 255) total++;
      end
    end
    cyc++;
  endtask

  // Drive one cycle of inputs, compare against the model, then advance a clock.
  task automatic cycle_io(input logic r, input logic [2:0] coins, input logic v,
                          input string tag, input bit do_check);
    reset            = r;
    bus.coin_one_in  = coins[0];
    bus.coin_two_in  = coins[1];
    bus.coin_five_in = coins[2];
    bus.vm_d         = v;
    #1;
    if (do_check) chk($sformatf("%s@%0d", tag, cyc), 32'(dut_outputs()), 32'(model_expect()));
    model_step(r, coins, v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle_io(1'b0, 3'b000, 1'b0, tag, 1'b1);
  endtask

  initial begin
    // rst, coins, vm, chk, strobe, rej, busy, count
    tbl[0] = '{1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, CW'(0)};
    tbl[1] = '{1'b0, 3'b010, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, CW'(0)};
    tbl[2] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1, CW'(1)};
    tbl[3] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b010, 3'b000, 1'b1, CW'(1)};
    tbl[4] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1, CW'(0)};
    tbl[5] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, CW'(0)};
    tbl[6] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, CW'(0)};

    reset            = 1'b1;
    bus.coin_one_in  = 1'b0;
    bus.coin_two_in  = 1'b0;
    bus.coin_five_in = 1'b0;
    bus.vm_d         = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and single $2 coin, against hand-derived vectors.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_strobe", i), 32'(strobe_now()), 32'(tbl[i].strobe));
        chk($sformatf("tbl%0d_reject", i), 32'(bus.coin_reject), 32'(tbl[i].rej));
        chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
        chk($sformatf("tbl%0d_count", i), 32'(bus.fifo_count), 32'(tbl[i].count));
      end
      cycle_io(tbl[i].rst, tbl[i].coins, tbl[i].vm, "tbl_model", tbl[i].chk);
    end

    // Three coins in one cycle: one, two, five two cycles apart.
    cycle_io(1'b0, 3'b111, 1'b0, "sim3", 1'b1);
    chk("sim3_count_full", 32'(bus.fifo_count), 32'd3);
    cycle_io(1'b0, 3'b000, 1'b0, "sim3", 1'b1);
    chk("sim3_first_one", 32'(strobe_now()), 32'(3'b001));
    cycle_io(1'b0, 3'b000, 1'b0, "sim3", 1'b1);
    cycle_io(1'b0, 3'b000, 1'b0, "sim3", 1'b1);
    chk("sim3_second_two", 32'(strobe_now()), 32'(3'b010));
    cycle_io(1'b0, 3'b000, 1'b0, "sim3", 1'b1);
    cycle_io(1'b0, 3'b000, 1'b0, "sim3", 1'b1);
    chk("sim3_third_five", 32'(strobe_now()), 32'(3'b100));
    cycle_io(1'b0, 3'b000, 1'b0, "sim3", 1'b1);
    chk("sim3_count_empty", 32'(bus.fifo_count), 32'd0);
    idle(4, "sim3_tail");

    // Overflow: reach 7 in CHECK (no pop), then three coins -> one fits.
    cycle_io(1'b0, 3'b111, 1'b0, "ovf", 1'b1);
    cycle_io(1'b0, 3'b011, 1'b0, "ovf", 1'b1);
    cycle_io(1'b0, 3'b111, 1'b0, "ovf", 1'b1);
    chk("ovf_count_7", 32'(bus.fifo_count), 32'd7);
    cycle_io(1'b0, 3'b111, 1'b0, "ovf", 1'b1);
    chk("ovf_reject", 32'(bus.coin_reject), 32'(3'b110));
    chk("ovf_count_8", 32'(bus.fifo_count), 32'd8);
    cycle_io(1'b0, 3'b000, 1'b0, "ovf", 1'b1);
    chk("ovf_reject_cleared", 32'(bus.coin_reject), 32'(3'b000));
    idle(24, "ovf_drain");

    // Dispense hold: vm_d in CHECK, then GAP silent HOLD cycles and IDLE.
    cycle_io(1'b0, 3'b111, 1'b0, "hold", 1'b1);
    cycle_io(1'b0, 3'b000, 1'b0, "hold", 1'b1);
    chk("hold_first_one", 32'(strobe_now()), 32'(3'b001));
    cycle_io(1'b0, 3'b000, 1'b0, "hold", 1'b1);
    cycle_io(1'b0, 3'b000, 1'b1, "hold", 1'b1);
    chk("hold_c4_quiet", 32'({strobe_now(), bus.busy}), 32'({3'b000, 1'b1}));
    cycle_io(1'b0, 3'b000, 1'b0, "hold", 1'b1);
    chk("hold_c5_quiet", 32'({strobe_now(), bus.busy}), 32'({3'b000, 1'b1}));
    cycle_io(1'b0, 3'b000, 1'b0, "hold", 1'b1);
    chk("hold_idle_quiet", 32'(strobe_now()), 32'(3'b000));
    cycle_io(1'b0, 3'b000, 1'b0, "hold", 1'b1);
    chk("hold_next_two", 32'(strobe_now()), 32'(3'b010));
    idle(10, "hold_drain");

    // Reset while in ISSUE with five coins queued; coin in reset cycle ignored.
    cycle_io(1'b0, 3'b111, 1'b0, "rst", 1'b1);
    cycle_io(1'b0, 3'b011, 1'b0, "rst", 1'b1);
    chk("rst_issue_strobe", 32'(strobe_now()), 32'(3'b001));
    cycle_io(1'b1, 3'b001, 1'b0, "rst", 1'b1);
    chk("rst_after", 32'({strobe_now(), bus.busy, bus.fifo_count}), 32'({3'b000, 1'b0, CW'(0)}));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rst_no_strobe%0d", i), 32'(strobe_now()), 32'(3'b000));
      cycle_io(1'b0, 3'b000, 1'b0, "rst_quiet", 1'b1);
    end

    // Randomized traffic with occasional resets and dispenses.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] coins;
      logic       v;
      logic       r;
      coins = ((i % 400) < 200) ? 3'($urandom) : 3'($urandom & $urandom & $urandom);
      v     = 1'($urandom_range(0, 1));
      r     = ($urandom_range(0, 199) == 0);
      cycle_io(r, coins, v, "rand", 1'b1);
    end
    idle(30, "final_drain");

`ifdef COIN_SEQ_STATS_EN
    // Saturation: push well over 255 coins from a clean reset.
    cycle_io(1'b1, 3'b000, 1'b0, "stats_rst", 1'b0);
    for (int i = 0; i < 560; i++) cycle_io(1'b0, 3'b001, 1'b0, "stats", 1'b1);
    idle(30, "stats_drain");
    chk("coin_total_sat", 32'(coin_total), 32'(total));
    chk("coin_total_255", 32'(coin_total), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coin_sequencer.md
COIN_SEQUENCER -- requirements
Module: coin_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, coin FIFO entries (power of two, 4..16).
REQ-002 SHALL have parameter GAP, default 2, idle cycles held after a dispense before the next coin is issued.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port coin_one_in  input  1  one-cycle pulse from the $1 slot sensor.
REQ-006 SHALL have port coin_two_in  input  1  one-cycle pulse from the $2 slot sensor.
REQ-007 SHALL have port coin_five_in  input  1  one-cycle pulse from the $5 slot sensor.
REQ-008 SHALL have port vm_d  input  1  dispense flag from the vending FSM.
REQ-009 SHALL have ports one, two, five  output  1 each  one-hot coin strobes to the vending FSM.
REQ-010 SHALL have port coin_reject  output  3  per-slot drop pulse, bits {five,two,one}.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE or the FIFO is not empty.
REQ-012 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL push all coins arriving in one cycle, in order one, two, five, into a FIFO of 2-bit coin codes.
REQ-014 SHALL compute free space before any same-cycle pop; coins beyond free space are dropped and their coin_reject bit pulses high for exactly one cycle, the cycle after arrival.
REQ-015 SHALL implement FSM states IDLE, ISSUE, CHECK, HOLD.
REQ-016 IDLE -> ISSUE when FIFO not empty; otherwise remain in IDLE.
REQ-017 ISSUE SHALL pop one entry and drive exactly one of one/two/five high for that single cycle, then go to CHECK.
REQ-018 CHECK SHALL sample vm_d: if 1 -> HOLD with the gap counter loaded to GAP; else -> ISSUE if FIFO not empty, else IDLE.
REQ-019 HOLD SHALL decrement the gap counter each cycle and go to IDLE when it reaches 1; GAP=0 SHALL be treated as 1.
REQ-020 one, two, five SHALL be zero in every state except ISSUE and SHALL never be high simultaneously.
REQ-021 Minimum spacing between consecutive coin strobes SHALL be 2 cycles (ISSUE, CHECK); after a dispense, 2+GAP cycles.
REQ-022 Coins arriving during HOLD SHALL be queued, not dropped, while space remains.
REQ-023 Simultaneous push and pop SHALL update fifo_count by (pushes - 1); the read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-024 reset SHALL clear the FIFO (fifo_count=0), set state IDLE, clear the gap counter, and drive one/two/five/coin_reject to 0 on the next edge.
REQ-025 reset mid-operation (any state) SHALL discard queued coins without issuing them; coin inputs in the reset cycle SHALL be ignored.
REQ-026 busy SHALL be 0 the cycle after reset.

Configuration
REQ-027 With COIN_SEQ_STATS_EN defined, the module SHALL add output coin_total (8-bit) counting issued coins, saturating at 255 and cleared by reset.
REQ-028 Without COIN_SEQ_STATS_EN, coin_total SHALL not exist and the counter logic SHALL not be synthesised; all other behaviour is identical.

Structure
REQ-029 Package coin_seq_pkg SHALL hold the state encoding (IDLE=0, ISSUE=1, CHECK=2, HOLD=3) and coin codes (NONE=0, ONE=1, TWO=2, FIVE=3).
REQ-030 The FIFO SHALL be a sub-module coin_fifo with up to 3 pushes and 1 pop per cycle, exposing count and empty.

Verification
REQ-031 Single coin: coin_two_in pulse at cycle 0 -> two=1 for exactly one cycle at cycle 2, fifo_count back to 0 at cycle 3.
REQ-032 Simultaneous coins: all three pulses in one cycle -> strobes one, two, five issued in that order, 2 cycles apart, fifo_count 3->0.
REQ-033 Overflow: DEPTH=8, FIFO holding 7 with no pop that cycle, three coins arrive -> one accepted, coin_reject=3'b110 for one cycle, fifo_count=8.
REQ-034 Dispense hold: vm_d=1 sampled in CHECK with GAP=2, 2 coins queued -> no strobe for 2 cycles of HOLD, then next strobe after IDLE->ISSUE.
REQ-035 Reset mid-run: 5 coins queued, reset asserted in ISSUE -> strobe ends, fifo_count=0, state IDLE, no further strobes.
REQ-036 Stats build: COIN_SEQ_STATS_EN defined, 260 coins issued -> coin_total=255; undefined build compiles without the coin_total port.
